// File: rtl/chan_sum_pkg.sv
// Shared constants and helpers for the time-multiplexed channel summer.
// State codes are plain localparams so older tools can consume them.
package chan_sum_pkg;

  localparam int unsigned NUM_CH_DEF = 35;
  localparam int unsigned IN_W_DEF   = 16;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StAccum = 2'd1;
  localparam logic [1:0] StOut   = 2'd2;

  // Narrowest accumulator that cannot overflow over num_ch samples of in_w bits.
  function automatic int unsigned acc_width(input int unsigned in_w, input int unsigned num_ch);
    return in_w + $clog2(num_ch);
  endfunction

endpackage

// File: rtl/chan_sum_acc.sv
// Dual I/Q signed accumulator with load/add/hold control and sign extension.
// o_nxt_* is the value the accumulator takes at the coming clock edge.
module chan_sum_acc
  import chan_sum_pkg::*;
#(
  parameter int unsigned IN_W  = IN_W_DEF,
  parameter int unsigned ACC_W = acc_width(IN_W_DEF, NUM_CH_DEF)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_load,
  input  logic                    i_add,
  input  logic signed [IN_W-1:0]  i_smp_i,
  input  logic signed [IN_W-1:0]  i_smp_q,
  output logic signed [ACC_W-1:0] o_nxt_i,
  output logic signed [ACC_W-1:0] o_nxt_q
);

  logic signed [ACC_W-1:0] r_acc_i;
  logic signed [ACC_W-1:0] r_acc_q;
  logic signed [ACC_W-1:0] w_ext_i;
  logic signed [ACC_W-1:0] w_ext_q;

  assign w_ext_i = {{(ACC_W - IN_W){i_smp_i[IN_W-1]}}, i_smp_i};
  assign w_ext_q = {{(ACC_W - IN_W){i_smp_q[IN_W-1]}}, i_smp_q};

  // Load takes priority so a frame restart never folds in the stale partial sum.
  always_comb begin
    o_nxt_i = r_acc_i;
    o_nxt_q = r_acc_q;
    if (i_load) begin
      o_nxt_i = w_ext_i;
      o_nxt_q = w_ext_q;
    end else if (i_add) begin
      o_nxt_i = r_acc_i + w_ext_i;
      o_nxt_q = r_acc_q + w_ext_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc_i <= '0;
      r_acc_q <= '0;
    end else begin
      r_acc_i <= o_nxt_i;
      r_acc_q <= o_nxt_q;
    end
  end

endmodule

// File: rtl/chan_sum_seq.sv
// Serial per-channel I/Q frame summer: SOF-framed beats in, one sum per frame out.
// Define CHSUM_MASK_EN to add a per-frame channel mask (ch_mask) and n_active output.
module chan_sum_seq
  import chan_sum_pkg::*;
#(
  parameter int unsigned NUM_CH = NUM_CH_DEF,
  parameter int unsigned IN_W   = IN_W_DEF,
  parameter int unsigned ACC_W  = acc_width(IN_W, NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic                    s_sof,
  input  logic signed [IN_W-1:0]  s_i,
  input  logic signed [IN_W-1:0]  s_q,
`ifdef CHSUM_MASK_EN
  input  logic [NUM_CH-1:0]       ch_mask,
  output logic [7:0]              n_active,
`endif
  output logic signed [ACC_W-1:0] sum_i,
  output logic signed [ACC_W-1:0] sum_q,
  output logic                    sum_valid,
  output logic                    frame_err,
  output logic                    busy,
  output logic [7:0]              ch_idx
);

  localparam logic [7:0] LastIdx = 8'(NUM_CH);

  logic [1:0]              r_state;
  logic [1:0]              w_state_nxt;
  logic [7:0]              r_ch_idx;
  logic [7:0]              w_ch_nxt;
  logic [7:0]              w_ch_inc;
  logic                    w_accept;
  logic                    w_load;
  logic                    w_add;
  logic                    w_done;
  logic                    w_err_nxt;
  logic signed [ACC_W-1:0] r_sum_i;
  logic signed [ACC_W-1:0] r_sum_q;
  logic                    r_sum_valid;
  logic                    r_frame_err;
  logic signed [ACC_W-1:0] w_nxt_i;
  logic signed [ACC_W-1:0] w_nxt_q;
  logic signed [IN_W-1:0]  w_smp_i;
  logic signed [IN_W-1:0]  w_smp_q;

  assign s_ready  = (r_state != StOut);
  assign w_accept = s_valid && s_ready;
  assign w_ch_inc = r_ch_idx + 8'd1;

`ifdef CHSUM_MASK_EN
  logic [NUM_CH-1:0] r_mask;
  logic [NUM_CH-1:0] w_mask_sh;
  logic [7:0]        r_n_active;
  logic [7:0]        w_pop;
  logic              w_mask_bit;

  // An SOF beat is channel 0 and uses the mask arriving with it, not the held one.
  assign w_mask_sh  = r_mask >> r_ch_idx;
  assign w_mask_bit = s_sof ? ch_mask[0] : w_mask_sh[0];
  assign w_smp_i    = w_mask_bit ? s_i : '0;
  assign w_smp_q    = w_mask_bit ? s_q : '0;
  assign n_active   = r_n_active;

  always_comb begin
    w_pop = '0;
    for (int k = 0; k < int'(NUM_CH); k++) begin
      w_pop = w_pop + 8'(ch_mask[k]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mask     <= '0;
      r_n_active <= '0;
    end else if (w_accept && s_sof) begin
      r_mask     <= ch_mask;
      r_n_active <= w_pop;
    end
  end
`else
  assign w_smp_i = s_i;
  assign w_smp_q = s_q;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_ch_nxt    = r_ch_idx;
    w_load      = 1'b0;
    w_add       = 1'b0;
    w_done      = 1'b0;
    w_err_nxt   = 1'b0;
    case (r_state)
      StIdle: begin
        if (w_accept) begin
          if (s_sof) begin
            w_load      = 1'b1;
            w_ch_nxt    = 8'd1;
            w_done      = (LastIdx == 8'd1);
            w_state_nxt = w_done ? StOut : StAccum;
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end
      StAccum: begin
        if (w_accept) begin
          if (s_sof) begin
            w_load      = 1'b1;
            w_err_nxt   = 1'b1;
            w_ch_nxt    = 8'd1;
            w_done      = (LastIdx == 8'd1);
            w_state_nxt = w_done ? StOut : StAccum;
          end else begin
            w_add       = 1'b1;
            w_ch_nxt    = w_ch_inc;
            w_done      = (w_ch_inc == LastIdx);
            w_state_nxt = w_done ? StOut : StAccum;
          end
        end
      end
      StOut: begin
        w_state_nxt = StIdle;
        w_ch_nxt    = 8'd0;
      end
      default: begin
        w_state_nxt = StIdle;
        w_ch_nxt    = 8'd0;
      end
    endcase
  end

  chan_sum_acc #(
    .IN_W  (IN_W),
    .ACC_W (ACC_W)
  ) u_acc (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_add   (w_add),
    .i_smp_i (w_smp_i),
    .i_smp_q (w_smp_q),
    .o_nxt_i (w_nxt_i),
    .o_nxt_q (w_nxt_q)
  );

  // Sums are captured from the accumulator's next value so they appear in the OUT cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StIdle;
      r_ch_idx    <= '0;
      r_sum_i     <= '0;
      r_sum_q     <= '0;
      r_sum_valid <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ch_idx    <= w_ch_nxt;
      r_sum_valid <= w_done;
      r_frame_err <= w_err_nxt;
      if (w_done) begin
        r_sum_i <= w_nxt_i;
        r_sum_q <= w_nxt_q;
      end
    end
  end

  assign sum_i     = r_sum_i;
  assign sum_q     = r_sum_q;
  assign sum_valid = r_sum_valid;
  assign frame_err = r_frame_err;
  assign busy      = (r_state != StIdle);
  assign ch_idx    = r_ch_idx;

endmodule

// File: tb/tb_chan_sum_seq.sv
// Bench for chan_sum_seq: constant frame table, hand corner sequences, random traffic
// against a frame-level model that sums a queue of accepted samples.
module tb_chan_sum_seq;

  localparam int NUM_CH = 35;
  localparam int IN_W   = 16;
  localparam int ACC_W  = 22;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                    rst;
  logic                    s_valid;
  logic                    s_ready;
  logic                    s_sof;
  logic signed [IN_W-1:0]  s_i;
  logic signed [IN_W-1:0]  s_q;
  logic signed [ACC_W-1:0] sum_i;
  logic signed [ACC_W-1:0] sum_q;
  logic                    sum_valid;
  logic                    frame_err;
  logic                    busy;
  logic [7:0]              ch_idx;
`ifdef CHSUM_MASK_EN
  logic [NUM_CH-1:0]       ch_mask;
  logic [7:0]              n_active;
`endif

  chan_sum_seq #(
    .NUM_CH (NUM_CH),
    .IN_W   (IN_W),
    .ACC_W  (ACC_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_sof     (s_sof),
    .s_i       (s_i),
    .s_q       (s_q),
`ifdef CHSUM_MASK_EN
    .ch_mask   (ch_mask),
    .n_active  (n_active),
`endif
    .sum_i     (sum_i),
    .sum_q     (sum_q),
    .sum_valid (sum_valid),
    .frame_err (frame_err),
    .busy      (busy),
    .ch_idx    (ch_idx)
  );

  int n_checks = 0;
  int n_errors = 0;
  int err_seen = 0;

  // Frame-level reference model
  int     m_cnt = 0;
  bit     m_out = 0;
  bit     m_sv  = 0;
  bit     m_err = 0;
  longint m_si  = 0;
  longint m_sq  = 0;
  longint m_qi[$];
  longint m_qq[$];
  logic [NUM_CH-1:0] m_mask = '1;
  int     m_nact = 0;

  task automatic chk(input string name, input logic signed [63:0] act,
                     input logic signed [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic model_step();
    longint ci;
    longint cq;
    bit     use_smp;
    m_sv = 0;
    m_err = 0;
    if (rst) begin
      m_cnt = 0;
      m_out = 0;
      m_si = 0;
      m_sq = 0;
      m_qi.delete();
      m_qq.delete();
      m_nact = 0;
    end else if (m_out) begin
      m_out = 0;
      m_cnt = 0;
    end else if (s_valid) begin
      use_smp = 1;
`ifdef CHSUM_MASK_EN
      if (s_sof) begin
        m_mask = ch_mask;
        m_nact = $countones(ch_mask);
      end
      use_smp = m_mask[s_sof ? 0 : m_cnt];
`endif
      ci = use_smp ? longint'(s_i) : 0;
      cq = use_smp ? longint'(s_q) : 0;
      if (s_sof) begin
        m_err = (m_cnt != 0);
        m_qi = {ci};
        m_qq = {cq};
        m_cnt = 1;
      end else if (m_cnt == 0) begin
        m_err = 1;
      end else begin
        m_qi.push_back(ci);
        m_qq.push_back(cq);
        m_cnt++;
      end
      if (m_cnt == NUM_CH) begin
        m_si = 0;
        m_sq = 0;
        foreach (m_qi[k]) m_si += m_qi[k];
        foreach (m_qq[k]) m_sq += m_qq[k];
        m_sv = 1;
        m_out = 1;
      end
    end
  endtask

  task automatic check_model();
    chk("s_ready", s_ready, !m_out);
    chk("sum_valid", sum_valid, m_sv);
    chk("frame_err", frame_err, m_err);
    chk("busy", busy, m_cnt != 0);
    chk("ch_idx", ch_idx, m_cnt);
    chk("sum_i", sum_i, m_si);
    chk("sum_q", sum_q, m_sq);
`ifdef CHSUM_MASK_EN
    chk("n_active", n_active, m_nact);
`endif
  endtask

  task automatic cycle(input bit r, input bit v, input bit sof, input longint i, input longint q);
    rst = r;
    s_valid = v;
    s_sof = sof;
    s_i = IN_W'(i);
    s_q = IN_W'(q);
    model_step();
    @(posedge clk);
    #1;
    check_model();
    err_seen += int'(frame_err);
  endtask

  task automatic send_frame(input longint i, input longint q);
    for (int k = 0; k < NUM_CH; k++) cycle(0, 1, k == 0, i, q);
  endtask

  typedef struct {
    longint i;
    longint q;
    longint exp_i;
    longint exp_q;
  } vec_t;

  vec_t tbl[5];

  initial begin
    tbl[0] = '{i: 1,      q: -1,     exp_i: 35,      exp_q: -35};
    tbl[1] = '{i: 32767,  q: -32768, exp_i: 1146845, exp_q: -1146880};
    tbl[2] = '{i: 2,      q: 2,      exp_i: 70,      exp_q: 70};
    tbl[3] = '{i: -1,     q: 3,      exp_i: -35,     exp_q: 105};
    tbl[4] = '{i: -32768, q: 32767,  exp_i: -1146880, exp_q: 1146845};

`ifdef CHSUM_MASK_EN
    ch_mask = '1;
`endif
    cycle(1, 0, 0, 0, 0);
    cycle(1, 1, 1, 5, 5);
    chk("rst_ready", s_ready, 1);
    chk("rst_sum_i", sum_i, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ch_idx", ch_idx, 0);

    // Constant-value full frames
    for (int t = 0; t < 5; t++) begin
      send_frame(tbl[t].i, tbl[t].q);
      chk("tbl_valid", sum_valid, 1);
      chk("tbl_ready_low", s_ready, 0);
      chk("tbl_sum_i", sum_i, tbl[t].exp_i);
      chk("tbl_sum_q", sum_q, tbl[t].exp_q);
      cycle(0, 0, 0, 0, 0);
      chk("tbl_ready_back", s_ready, 1);
      chk("tbl_valid_pulse", sum_valid, 0);
      chk("tbl_hold_i", sum_i, tbl[t].exp_i);
    end

    // Early restart: partial frame of I=5 abandoned by a new SOF
    err_seen = 0;
    for (int k = 0; k < 10; k++) cycle(0, 1, k == 0, 5, 0);
    send_frame(1, 0);
    chk("restart_err_count", err_seen, 1);
    chk("restart_valid", sum_valid, 1);
    chk("restart_sum_i", sum_i, 35);
    cycle(0, 0, 0, 0, 0);

    // Orphan beats in IDLE
    err_seen = 0;
    for (int k = 0; k < 3; k++) begin
      cycle(0, 1, 0, 9, 9);
      chk("orphan_err", frame_err, 1);
      chk("orphan_busy", busy, 0);
      chk("orphan_valid", sum_valid, 0);
    end
    cycle(0, 0, 0, 0, 0);
    chk("orphan_err_count", err_seen, 3);

    // Reset mid-frame, beat presented alongside rst is dropped
    for (int k = 0; k < 20; k++) cycle(0, 1, k == 0, 9, 9);
    chk("mid_ch_idx", ch_idx, 20);
    cycle(1, 1, 0, 7, 7);
    chk("mid_rst_sum_i", sum_i, 0);
    chk("mid_rst_sum_q", sum_q, 0);
    chk("mid_rst_valid", sum_valid, 0);
    chk("mid_rst_err", frame_err, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ch_idx", ch_idx, 0);
    chk("mid_rst_ready", s_ready, 1);
    err_seen = 0;
    send_frame(2, 2);
    chk("post_rst_sum_i", sum_i, 70);
    chk("post_rst_no_err", err_seen, 0);
    cycle(0, 0, 0, 0, 0);

`ifdef CHSUM_MASK_EN
    for (int k = 0; k < NUM_CH; k++) ch_mask[k] = (k % 2 == 0);
    send_frame(1, 1);
    chk("mask_sum_i", sum_i, 18);
    chk("mask_n_active", n_active, 18);
    ch_mask = '1;
    cycle(0, 0, 0, 0, 0);
`endif

    // Random traffic against the model
    for (int n = 0; n < 4000; n++) begin
      bit r;
      bit v;
      bit sof;
      r = ($urandom_range(0, 399) == 0);
      v = ($urandom_range(0, 9) < 8);
      sof = (m_cnt == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 79) == 0);
`ifdef CHSUM_MASK_EN
      ch_mask = {$urandom, $urandom};
`endif
      cycle(r, v, sof, longint'($urandom_range(0, 65535)), longint'($urandom_range(0, 65535)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
